// File: rtl/icache_pkg.sv
// Shared types for the instruction cache and its miss-refill engine.
package icache_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned LINE_BITS   = LINE_WORDS * WORD_W;
    localparam int unsigned LINE_ADDR_W = 28;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;
    typedef logic [LINE_BITS-1:0]   line_data_t;
    typedef logic [1:0]             word_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } refill_state_t;

    // Word-aligned byte address of word idx inside a line.
    function automatic logic [31:0] word_addr(line_addr_t line, word_idx_t idx);
        return {line, idx, 2'b00};
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Miss request, imem read and line fill signals between cache, imem and refill engine.
interface icache_refill_if;
    import icache_pkg::*;

    logic        miss_valid;
    line_addr_t  miss_line;
    logic        miss_ready;
    logic        flush;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        fill_valid;
    line_addr_t  fill_line;
    line_data_t  fill_data;
    logic        fill_ready;
    logic        busy;

    // Cache and imem side: issues misses, returns read data, consumes fills.
    modport master (
        output miss_valid, miss_line, flush, mem_rdata, fill_ready,
        input  miss_ready, mem_addr, fill_valid, fill_line, fill_data, busy
    );

    // Refill engine side.
    modport slave (
        input  miss_valid, miss_line, flush, mem_rdata, fill_ready,
        output miss_ready, mem_addr, fill_valid, fill_line, fill_data, busy
    );

endinterface

// File: rtl/refill_lat_cnt.sv
// Loadable down-counter that times the imem access latency; flags when it reaches zero.
module refill_lat_cnt #(
    parameter int unsigned LATENCY = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/icache_refill.sv
// Instruction cache miss-refill engine: waits out the imem latency, reads the four words
// of a line, and presents the assembled line on a valid/ready fill port.
module icache_refill #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic          clk,
    input logic          rst_n,
    icache_refill_if.slave bus
);
    import icache_pkg::*;

    if (LATENCY < 1) begin : g_bad_latency
        $error("icache_refill: LATENCY must be >= 1");
    end
    if (LINE_WORDS != icache_pkg::LINE_WORDS) begin : g_bad_line_words
        $error("icache_refill: LINE_WORDS must be 4");
    end

    refill_state_t state_q, state_d;
    line_addr_t    line_q, line_d;
    word_idx_t     idx_q, idx_d;
    line_data_t    data_q, data_d;

    logic accept;
    logic capture;
    logic cnt_dec;
    logic cnt_zero;
    logic last_word;

    assign last_word = (idx_q == 2'd3);

    refill_lat_cnt #(
        .LATENCY (LATENCY)
    ) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush aborts any fill and always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.miss_valid && !bus.flush) state_d = WAIT;
            end
            WAIT: begin
                if (bus.flush)         state_d = IDLE;
                else if (cnt_zero)     state_d = BURST;
            end
            BURST: begin
                if (bus.flush)         state_d = IDLE;
                else if (last_word)    state_d = DONE;
            end
            DONE: begin
                if (bus.flush || bus.fill_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath controls decoded from the current state.
    always_comb begin
        accept         = 1'b0;
        capture        = 1'b0;
        cnt_dec        = 1'b0;
        bus.miss_ready = 1'b0;
        bus.fill_valid = 1'b0;
        bus.busy       = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.busy       = 1'b0;
                bus.miss_ready = !bus.flush;
                accept         = bus.miss_valid && !bus.flush;
            end
            WAIT: begin
                cnt_dec = !cnt_zero && !bus.flush;
                capture = cnt_zero && !bus.flush;
            end
            BURST: begin
                capture = !bus.flush;
            end
            DONE: begin
                bus.fill_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values: latch the line on accept, place each captured word by idx.
    always_comb begin
        line_d = line_q;
        idx_d  = idx_q;
        data_d = data_q;
        if (accept) begin
            line_d = bus.miss_line;
            idx_d  = '0;
        end
        if (capture) begin
            data_d[{idx_q, 5'd0} +: WORD_W] = bus.mem_rdata;
            // idx parks at word 3 so mem_addr stays on the last word through DONE.
            if (!last_word) idx_d = idx_q + 2'd1;
        end
    end

    // Datapath registers; previous line data is kept until overwritten by new captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            line_q <= line_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign bus.mem_addr  = word_addr(line_q, idx_q);
    assign bus.fill_line = line_q;
    assign bus.fill_data = data_q;

    // A stalled fill must hold its line and data until taken or flushed.
    a_fill_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.fill_valid && !bus.fill_ready && !bus.flush
        |=> bus.fill_valid && $stable(bus.fill_data) && $stable(bus.fill_line));

    // Requests are only offered while idle.
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.miss_ready |-> (state_q == IDLE));

    // The word index never wraps back to zero during a fill.
    a_idx_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BURST) && last_word && !bus.flush |=> (idx_q == 2'd3));

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: default-latency and LATENCY=1 instances with an imem model.
module tb_icache_refill;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_refill_if bus10 ();
    icache_refill_if bus1 ();

    icache_refill #(
        .LATENCY    (10),
        .LINE_WORDS (4)
    ) u_dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10)
    );

    icache_refill #(
        .LATENCY    (1),
        .LINE_WORDS (4)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // imem: word at byte 0x40 is 0xA0, each following word +1 (0x80 -> 0xB0, 0x100 -> 0xD0).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + {2'b00, a[31:2]} - 32'h10;
    endfunction

    assign bus10.mem_rdata = mem_word(bus10.mem_addr);
    assign bus1.mem_rdata  = mem_word(bus1.mem_addr);

    localparam logic [127:0] DATA_4  = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] DATA_8  = 128'h000000B3_000000B2_000000B1_000000B0;
    localparam logic [127:0] DATA_C  = 128'h000000C3_000000C2_000000C1_000000C0;
    localparam logic [127:0] DATA_10 = 128'h000000D3_000000D2_000000D1_000000D0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Edges from accept until fill_valid on the default instance, bounded.
    task automatic wait_fill(output int k);
        k = 0;
        while (!bus10.fill_valid && k < 40) begin
            step();
            k++;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_miss_ready"}, bus10.miss_ready, 1'b1);
        check({pfx, "_fill_valid"}, bus10.fill_valid, 1'b0);
        check({pfx, "_busy"},       bus10.busy,       1'b0);
        check({pfx, "_mem_addr"},   bus10.mem_addr,   32'h0);
        check({pfx, "_fill_line"},  bus10.fill_line,  28'h0);
        check({pfx, "_fill_data"},  bus10.fill_data,  128'h0);
    endtask

    logic [31:0] addr_seen [20];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  k;
        logic saw;

        rst_n = 1'b1;
        bus10.miss_valid = 1'b0; bus10.miss_line = '0; bus10.flush = 1'b0; bus10.fill_ready = 1'b0;
        bus1.miss_valid  = 1'b0; bus1.miss_line  = '0; bus1.flush  = 1'b0; bus1.fill_ready  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic fill of line 4 with fill_ready held high.
        bus10.miss_valid = 1'b1; bus10.miss_line = 28'h4; bus10.fill_ready = 1'b1;
        step();
        bus10.miss_valid = 1'b0;
        check("basic_busy", bus10.busy, 1'b1);
        check("basic_miss_ready", bus10.miss_ready, 1'b0);
        addr_seen[0] = bus10.mem_addr;
        k = 0;
        while (!bus10.fill_valid && k < 40) begin
            step();
            k++;
            if (k < 20) addr_seen[k] = bus10.mem_addr;
        end
        check("basic_latency", k, 13);
        check("basic_addr_e0", addr_seen[0], 32'h40);
        check("basic_addr_e9", addr_seen[9], 32'h40);
        check("basic_addr_e10", addr_seen[10], 32'h44);
        check("basic_addr_e11", addr_seen[11], 32'h48);
        check("basic_addr_e12", addr_seen[12], 32'h4C);
        check("basic_data", bus10.fill_data, DATA_4);
        check("basic_line", bus10.fill_line, 28'h4);
        step();
        check("basic_done_valid", bus10.fill_valid, 1'b0);
        check("basic_done_busy", bus10.busy, 1'b0);
        check("basic_done_ready", bus10.miss_ready, 1'b1);

        // Backpressure on line C; a second miss during DONE must be ignored.
        bus10.fill_ready = 1'b0; bus10.miss_valid = 1'b1; bus10.miss_line = 28'hC;
        step();
        bus10.miss_valid = 1'b0;
        wait_fill(k);
        check("bp_latency", k, 13);
        for (int i = 0; i < 5; i++) begin
            bus10.miss_valid = 1'b1; bus10.miss_line = 28'h10;
            #1;
            check("bp_miss_ready", bus10.miss_ready, 1'b0);
            step();
            check("bp_valid_hold", bus10.fill_valid, 1'b1);
            check("bp_data_hold", bus10.fill_data, DATA_C);
            check("bp_line_hold", bus10.fill_line, 28'hC);
        end
        bus10.miss_valid = 1'b0; bus10.fill_ready = 1'b1;
        step();
        check("bp_release_valid", bus10.fill_valid, 1'b0);
        check("bp_release_busy", bus10.busy, 1'b0);
        check("bp_ignored_line", bus10.fill_line, 28'hC);
        check("bp_retained_data", bus10.fill_data, DATA_C);

        // Flush in the fifth WAIT cycle after accept.
        bus10.miss_valid = 1'b1; bus10.miss_line = 28'h14;
        step();
        bus10.miss_valid = 1'b0;
        repeat (4) step();
        bus10.flush = 1'b1;
        step();
        bus10.flush = 1'b0;
        check("fw_busy", bus10.busy, 1'b0);
        saw = 1'b0;
        repeat (20) begin
            step();
            if (bus10.fill_valid || bus10.busy) saw = 1'b1;
        end
        check("fw_no_fill", saw, 1'b0);
        check("fw_data_kept", bus10.fill_data, DATA_C);
        bus10.miss_valid = 1'b1; bus10.miss_line = 28'h8;
        step();
        bus10.miss_valid = 1'b0;
        wait_fill(k);
        check("fw_refill_latency", k, 13);
        check("fw_refill_data", bus10.fill_data, DATA_8);
        check("fw_refill_line", bus10.fill_line, 28'h8);
        step();

        // Flush and miss together in IDLE: flush wins.
        bus10.flush = 1'b1; bus10.miss_valid = 1'b1; bus10.miss_line = 28'h20;
        #1;
        check("fi_miss_ready", bus10.miss_ready, 1'b0);
        step();
        bus10.flush = 1'b0; bus10.miss_valid = 1'b0;
        check("fi_busy", bus10.busy, 1'b0);
        check("fi_mem_addr", bus10.mem_addr, 32'h8C);
        check("fi_fill_line", bus10.fill_line, 28'h8);

        // Flush while the fill is stalled in DONE.
        bus10.fill_ready = 1'b0; bus10.miss_valid = 1'b1; bus10.miss_line = 28'h4;
        step();
        bus10.miss_valid = 1'b0;
        wait_fill(k);
        check("fd_latency", k, 13);
        bus10.flush = 1'b1;
        step();
        bus10.flush = 1'b0;
        check("fd_valid", bus10.fill_valid, 1'b0);
        check("fd_busy", bus10.busy, 1'b0);
        check("fd_data_kept", bus10.fill_data, DATA_4);

        // Asynchronous reset once word 1 has been captured.
        bus10.fill_ready = 1'b1; bus10.miss_valid = 1'b1; bus10.miss_line = 28'h10;
        step();
        bus10.miss_valid = 1'b0;
        k = 0;
        while (bus10.mem_addr != 32'h108 && k < 40) begin
            step();
            k++;
        end
        check("ar_reach_word2", k, 11);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("ar");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus10.miss_valid = 1'b1; bus10.miss_line = 28'h10;
        step();
        bus10.miss_valid = 1'b0;
        wait_fill(k);
        check("ar_refill_latency", k, 13);
        check("ar_refill_data", bus10.fill_data, DATA_10);
        check("ar_refill_line", bus10.fill_line, 28'h10);
        step();

        // LATENCY=1 instance: word 0 captured at E1, fill_valid after E4.
        bus1.fill_ready = 1'b1; bus1.miss_valid = 1'b1; bus1.miss_line = 28'h4;
        step();
        bus1.miss_valid = 1'b0;
        check("l1_e0_addr", bus1.mem_addr, 32'h40);
        check("l1_e0_busy", bus1.busy, 1'b1);
        step();
        check("l1_e1_addr", bus1.mem_addr, 32'h44);
        step();
        step();
        check("l1_e3_addr", bus1.mem_addr, 32'h4C);
        check("l1_e3_valid", bus1.fill_valid, 1'b0);
        step();
        check("l1_e4_valid", bus1.fill_valid, 1'b1);
        check("l1_e4_data", bus1.fill_data, DATA_4);
        check("l1_e4_line", bus1.fill_line, 28'h4);
        step();
        check("l1_done_valid", bus1.fill_valid, 1'b0);
        check("l1_done_busy", bus1.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
